// File: rtl/demux1_2_buf.sv
// demux1_2_buf: buffered 1-to-2 demultiplexer.
// One valid/ready input stream is spread over two output channels, either by a
// per-beat select bit (s0) or by an internal round-robin pointer (auto=1).
// Each channel owns a small FIFO so a stalled consumer only blocks its own
// channel. Per-channel counters record delivered beats for bring-up/debug.
//
// Handshake rule (input and both outputs): a beat transfers on a rising edge
// where valid and ready are both high. Valid never depends on ready. i_ready
// depends on s0, auto and FIFO state only, never on i_valid.
module demux1_2_buf #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic             s0,
   input  logic             auto,
   output logic [WIDTH-1:0] y0,
   output logic             y0_valid,
   input  logic             y0_ready,
   output logic [WIDTH-1:0] y1,
   output logic             y1_valid,
   input  logic             y1_ready,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1,
   output logic             rr_next
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   // Channel-indexed state: index 0 feeds y0, index 1 feeds y1.
   logic [WIDTH-1:0] mem_q [2][DEPTH];
   logic [WIDTH-1:0] mem_d [2][DEPTH];
   logic [PW-1:0]    wr_q  [2];
   logic [PW-1:0]    wr_d  [2];
   logic [PW-1:0]    rd_q  [2];
   logic [PW-1:0]    rd_d  [2];
   logic [CNT_W-1:0] cnt_q [2];
   logic [CNT_W-1:0] cnt_d [2];
   logic             rr_q;
   logic             rr_d;

   logic [1:0] full;
   logic [1:0] empty;
   logic [1:0] push;
   logic [1:0] pop;
   logic       tgt;
   logic       in_hs;

   // FIFO status: equal pointers mean empty, MSB-only difference means full.
   always_comb begin
      full  = '0;
      empty = '0;
      for (int k = 0; k < 2; k++) begin
         empty[k] = (wr_q[k] == rd_q[k]);
         full[k]  = (wr_q[k][PW-1] != rd_q[k][PW-1]) &&
                    (wr_q[k][AW-1:0] == rd_q[k][AW-1:0]);
      end
   end

   // Target selection and handshakes; a full target blocks even if it pops.
   always_comb begin
      tgt     = auto ? rr_q : s0;
      i_ready = rst_n & ~full[tgt];
      in_hs   = i_valid & i_ready;
      push[0] = in_hs & ~tgt;
      push[1] = in_hs & tgt;
      pop[0]  = ~empty[0] & y0_ready;
      pop[1]  = ~empty[1] & y1_ready;
   end

   // Next-state for FIFO storage, pointers, counters and round-robin pointer.
   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      rr_d  = rr_q;
      for (int k = 0; k < 2; k++) begin
         if (push[k]) begin
            mem_d[k][wr_q[k][AW-1:0]] = i;
            wr_d[k] = wr_q[k] + 1'b1;
         end
         if (pop[k]) begin
            rd_d[k]  = rd_q[k] + 1'b1;
            cnt_d[k] = cnt_q[k] + 1'b1;
         end
      end
      if (auto && in_hs) begin
         rr_d = ~rr_q;
      end
   end

   // State registers; reset discards buffered beats and clears storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            for (int e = 0; e < DEPTH; e++) begin
               mem_q[k][e] <= '0;
            end
            wr_q[k]  <= '0;
            rd_q[k]  <= '0;
            cnt_q[k] <= '0;
         end
         rr_q <= 1'b0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         rr_q  <= rr_d;
      end
   end

   assign y0       = mem_q[0][rd_q[0][AW-1:0]];
   assign y1       = mem_q[1][rd_q[1][AW-1:0]];
   assign y0_valid = ~empty[0];
   assign y1_valid = ~empty[1];
   assign cnt0     = cnt_q[0];
   assign cnt1     = cnt_q[1];
   assign rr_next  = rr_q;

endmodule
